// File: rtl/aes_block_streamer.sv
// aes_block_streamer: packs stream words into AES blocks through a block FIFO and unpacks result blocks into words; AES_STREAMER_BYTESWAP_EN byte-reverses every word
module aes_block_streamer #(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128,
  parameter int FD     = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_blocks_i,
  input  logic              in_valid_i,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              blk_valid_o,
  output logic [BLK_W-1:0]  blk_data_o,
  input  logic              blk_ready_i,
  input  logic              res_valid_i,
  input  logic [BLK_W-1:0]  res_data_i,
  output logic              res_ready_o,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  blk_in_cnt_o,
  output logic [CNT_W-1:0]  blk_out_cnt_o
);
  localparam int WPB = BLK_W / WORD_W;
  localparam int IW  = WPB > 1 ? $clog2(WPB) : 1;
  localparam int PW  = FD > 1 ? $clog2(FD) : 1;
  localparam int FW  = $clog2(FD + 1);
  if (BLK_W % WORD_W != 0) begin : g_bad_blk
    $error("BLK_W must be a multiple of WORD_W");
  end
  if (FD < 1) begin : g_bad_fd
    $error("FD must be at least 1");
  end
`ifdef AES_STREAMER_BYTESWAP_EN
  if (WORD_W % 8 != 0) begin : g_bad_word
    $error("WORD_W must be a multiple of 8 for byte swapping");
  end
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic [WORD_W-1:0] swap(input logic [WORD_W-1:0] w);
    swap = '0;
`ifdef AES_STREAMER_BYTESWAP_EN
    for (int b = 0; b < WORD_W / 8; b++) swap[8*b +: 8] = w[WORD_W-8-8*b +: 8];
`else
    swap = w;
`endif
  endfunction
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    inc = p == PW'(FD - 1) ? '0 : p + PW'(1);
  endfunction
  state_e state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [IW-1:0] pack_idx_q, pack_idx_d, out_idx_q, out_idx_d;
  logic [BLK_W-1:0] pack_q, pack_d, held_q, held_d, blk_w;
  logic [BLK_W-1:0] mem_q [FD];
  logic [PW-1:0] wr_q, rd_q;
  logic [FW-1:0] fcnt_q;
  logic holding_q, holding_d;
  logic run, go, full, empty, pack_last, out_last, in_fire, push, pop, res_fire, out_fire, emit;
  assign run = state_q == RUN;
  assign go = state_q == IDLE && start_i;
  assign full = fcnt_q == FW'(FD);
  assign empty = fcnt_q == '0;
  assign pack_last = pack_idx_q == IW'(WPB - 1);
  assign out_last = out_idx_q == IW'(WPB - 1);
  assign in_ready_o = run && enable_i && in_cnt_q < n_q && !(pack_last && full);
  assign in_fire = in_valid_i && in_ready_o;
  assign push = in_fire && pack_last;
  assign blk_valid_o = !empty;
  assign blk_data_o = empty ? '0 : mem_q[rd_q];
  assign pop = blk_valid_o && blk_ready_i;
  // A held block may be replaced on its last word only if the job still needs another result
  assign res_ready_o = run && enable_i && (holding_q
    ? out_last && out_ready_i && ({1'b0, out_cnt_q} + (CNT_W+1)'(1)) < {1'b0, n_q}
    : out_cnt_q < n_q);
  assign res_fire = res_valid_i && res_ready_o;
  assign out_valid_o = holding_q;
  assign out_data_o = holding_q ? swap(held_q[out_idx_q*WORD_W +: WORD_W]) : '0;
  assign out_fire = holding_q && out_ready_i;
  assign emit = out_fire && out_last;
  assign busy_o = run;
  assign done_o = state_q == DONE;
  assign blk_in_cnt_o = in_cnt_q;
  assign blk_out_cnt_o = out_cnt_q;
  always_comb begin
    blk_w = pack_q;
    blk_w[pack_idx_q*WORD_W +: WORD_W] = swap(in_data_i);
    pack_d = in_fire ? (pack_last ? '0 : blk_w) : pack_q;
    pack_idx_d = go ? '0 : in_fire ? (pack_last ? '0 : pack_idx_q + IW'(1)) : pack_idx_q;
    out_idx_d = go ? '0 : out_fire ? (out_last ? '0 : out_idx_q + IW'(1)) : out_idx_q;
    in_cnt_d = go ? '0 : in_cnt_q + CNT_W'(push);
    out_cnt_d = go ? '0 : out_cnt_q + CNT_W'(emit);
    holding_d = res_fire || (holding_q && !emit);
    held_d = res_fire ? res_data_i : held_q;
    n_d = go ? num_blocks_i : n_q;
    state_d = state_q == IDLE ? (start_i ? (num_blocks_i == '0 ? DONE : RUN) : IDLE)
            : state_q == RUN ? (out_cnt_d == n_q ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= IDLE;
      n_q <= '0;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      pack_idx_q <= '0;
      out_idx_q <= '0;
      pack_q <= '0;
      held_q <= '0;
      holding_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      pack_idx_q <= pack_idx_d;
      out_idx_q <= out_idx_d;
      pack_q <= pack_d;
      held_q <= held_d;
      holding_q <= holding_d;
      wr_q <= push ? inc(wr_q) : wr_q;
      rd_q <= pop ? inc(rd_q) : rd_q;
      fcnt_q <= fcnt_q + FW'(push) - FW'(pop);
    end
  end
  always_ff @(posedge clk_i) if (push) mem_q[wr_q] <= blk_w;
endmodule

// File: tb/tb_aes_block_streamer.sv
// tb_aes_block_streamer: random handshake bench with a queue-based word/block model and an XOR-key AES stand-in
module tb_aes_block_streamer;
  logic clk = 1'b0;
  logic rst, clear, enable, start, in_valid, in_ready, blk_valid, blk_ready;
  logic res_valid, res_ready, out_valid, out_ready, busy, done;
  logic [15:0] num_blocks, blk_in_cnt, blk_out_cnt;
  logic [31:0] in_data, out_data, key;
  logic [127:0] blk_data, res_data, first_blk;
  logic [31:0] send_q[$], exp_out[$];
  logic [127:0] exp_blk[$], core_q[$];
  int tests = 0, fails = 0;
  int acc_words, done_cnt, cyc, out_n, first_out, last_out, w4_cyc, bv_cyc, pr, n;
  bit blk_hold, running;

  always #5 clk = ~clk;

  aes_block_streamer dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable), .start_i(start),
    .num_blocks_i(num_blocks), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .blk_valid_o(blk_valid), .blk_data_o(blk_data), .blk_ready_i(blk_ready),
    .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done), .blk_in_cnt_o(blk_in_cnt), .blk_out_cnt_o(blk_out_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pw(input logic [31:0] w);
`ifdef AES_STREAMER_BYTESWAP_EN
    return {<<8{w}};
`else
    return w;
`endif
  endfunction

  function automatic bit roll();
    return pr >= 100 || int'($urandom_range(99)) < pr;
  endfunction

  task automatic step();
    bit in_f, res_f;
    @(negedge clk);
    in_f = in_valid && in_ready;
    res_f = res_valid && res_ready;
    if (in_f) begin
      acc_words++;
      if (send_q.size() == 0) chk("in_saturate", 1, 0);
      else void'(send_q.pop_front());
      if (acc_words == 4 && w4_cyc < 0) w4_cyc = cyc;
    end
    if (blk_valid && bv_cyc < 0) begin
      bv_cyc = cyc;
      first_blk = blk_data;
    end
    if (blk_valid && blk_ready) begin
      if (exp_blk.size() == 0) chk("blk_extra", 1, 0);
      else chk("blk_data", blk_data, exp_blk.pop_front());
      core_q.push_back(blk_data);
    end
    if (res_f) void'(core_q.pop_front());
    if (out_valid && out_ready) begin
      if (exp_out.size() == 0) chk("out_extra", 1, 0);
      else chk("out_data", out_data, exp_out.pop_front());
      if (out_n == 0) first_out = cyc;
      last_out = cyc;
      out_n++;
    end
    if (done) done_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (in_f) in_valid = 0;
    if (running && !in_valid && roll()) begin
      in_valid = 1;
      in_data = send_q.size() > 0 ? send_q[0] : $urandom();
    end
    blk_ready = !blk_hold && roll();
    if (res_f) res_valid = 0;
    if (!res_valid && core_q.size() > 0 && roll()) begin
      res_valid = 1;
      res_data = core_q[0] ^ {4{key}};
    end
    out_ready = roll();
    enable = pr >= 100 || $urandom_range(7) != 0;
  endtask

  task automatic fill(input int nb);
    send_q.delete();
    repeat (nb * 4) send_q.push_back($urandom());
  endtask

  task automatic start_job(input int nb);
    logic [127:0] b;
    exp_blk.delete();
    exp_out.delete();
    core_q.delete();
    for (int i = 0; i < nb; i++) begin
      b = '0;
      for (int k = 0; k < 4; k++) b[k*32 +: 32] = pw(send_q[i*4+k]);
      exp_blk.push_back(b);
    end
    foreach (send_q[i]) exp_out.push_back(send_q[i] ^ pw(key));
    acc_words = 0; done_cnt = 0; out_n = 0; w4_cyc = -1; bv_cyc = -1;
    res_valid = 0;
    num_blocks = 16'(nb);
    start = 1;
    running = 1;
    step();
    start = 0;
  endtask

  task automatic finish_job(input int nb, input string tag);
    int lim;
    lim = cyc + 4000;
    while (done_cnt == 0 && cyc < lim) step();
    chk({tag, "_done_seen"}, done_cnt != 0, 1);
    running = 0;
    in_valid = 0;
    step();
    step();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_in_cnt"}, blk_in_cnt, nb);
    chk({tag, "_out_cnt"}, blk_out_cnt, nb);
    chk({tag, "_words"}, acc_words, nb * 4);
    chk({tag, "_out_left"}, exp_out.size(), 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic abort_with(input bit use_clear, input string tag);
    running = 0; in_valid = 0; res_valid = 0;
    if (use_clear) clear = 1; else rst = 1;
    step();
    clear = 0; rst = 0;
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_blk_valid"}, blk_valid, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_cnt"}, blk_in_cnt, 0);
    step();
    step();
    chk({tag, "_no_done"}, done_cnt, 0);
  endtask

  initial begin
    rst = 1; clear = 0; enable = 0; start = 0; num_blocks = 0;
    in_valid = 0; in_data = 0; blk_ready = 0; res_valid = 0; res_data = 0; out_ready = 0;
    pr = 100; key = 0; running = 0; blk_hold = 0; cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_blk_data", blk_data, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_counts", {blk_in_cnt, blk_out_cnt}, 0);
    // directed single block
    send_q = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    start_job(1);
    finish_job(1, "t1");
    chk("t1_first_blk", first_blk, {pw(32'h0C0D0E0F), pw(32'h08090A0B), pw(32'h04050607), pw(32'h00010203)});
    chk("t1_latency", bv_cyc - w4_cyc, 1);
    // FIFO backpressure: only 11 words fit while the core refuses blocks
    fill(3);
    blk_hold = 1;
    start_job(3);
    repeat (20) step();
    chk("t3_words", acc_words, 11);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_blk_valid", blk_valid, 1);
    blk_hold = 0;
    finish_job(3, "t3");
    // loopback, full throughput
    fill(2);
    start_job(2);
    finish_job(2, "t4");
    chk("t4_nout", out_n, 8);
    chk("t4_nobubble", last_out - first_out, 7);
    // zero-length job
    send_q.delete();
    start_job(0);
    chk("t5_done", done, 1);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_res_ready", res_ready, 0);
    step();
    chk("t5_done_end", done, 0);
    chk("t5_in_ready_end", in_ready, 0);
    running = 0; in_valid = 0;
    step();
    // reset after two words, then a fresh job
    fill(1);
    start_job(1);
    for (int g = 0; g < 50 && acc_words < 2; g++) step();
    abort_with(0, "t6");
    fill(1);
    start_job(1);
    finish_job(1, "t6b");
    // soft clear after one block pushed
    fill(2);
    start_job(2);
    for (int g = 0; g < 50 && acc_words < 5; g++) step();
    abort_with(1, "t7");
    // random jobs
    repeat (6) begin
      n = $urandom_range(1, 5);
      pr = $urandom_range(40, 90);
      key = $urandom();
      fill(n);
      start_job(n);
      finish_job(n, "rnd");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
